// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer owning HI/LO, with D-stage stall request.
// Optional MDU_DIVZERO_KEEP_EN: divide by zero leaves HI/LO unchanged at completion.
module mdu_sequencer #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        d_is_md,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        md_stall
);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   logic [3:0]  cnt_reg;
   logic [31:0] hi_reg;
   logic [31:0] lo_reg;
   logic [31:0] res_hi_reg;
   logic [31:0] res_lo_reg;
   logic        keep_reg;

   logic        long_op;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic        b_zero;
   logic [31:0] div_den;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quot;
   logic [31:0] rem;
   logic [31:0] res_hi_next;
   logic [31:0] res_lo_next;
   logic        keep_next;

   assign busy     = (cnt_reg != 4'd0);
   assign hi       = hi_reg;
   assign lo       = lo_reg;
   assign long_op  = ~md_op[2];
   assign md_stall = d_is_md && (busy || (start && long_op));

   assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign prod_u = {32'd0, a} * {32'd0, b};

   // Signed divide is done on magnitudes so that the most-negative / -1 case
   // wraps to 0x80000000 without relying on simulator-specific behaviour.
   assign a_neg   = (md_op == OP_DIV) && a[31];
   assign b_neg   = (md_op == OP_DIV) && b[31];
   assign a_mag   = a_neg ? (~a + 32'd1) : a;
   assign b_mag   = b_neg ? (~b + 32'd1) : b;
   assign b_zero  = (b == 32'd0);
   assign div_den = b_zero ? 32'd1 : b_mag;
   assign q_mag   = a_mag / div_den;
   assign r_mag   = a_mag % div_den;
   assign quot    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
   assign rem     = a_neg ? (~r_mag + 32'd1) : r_mag;

   always_comb begin
      res_hi_next = 32'd0;
      res_lo_next = 32'd0;
      keep_next   = 1'b0;
      case (md_op)
         OP_MULT: begin
            res_hi_next = prod_s[63:32];
            res_lo_next = prod_s[31:0];
         end
         OP_MULTU: begin
            res_hi_next = prod_u[63:32];
            res_lo_next = prod_u[31:0];
         end
         OP_DIV, OP_DIVU: begin
            if (b_zero) begin
               res_hi_next = a;
               res_lo_next = 32'hFFFF_FFFF;
`ifdef MDU_DIVZERO_KEEP_EN
               keep_next   = 1'b1;
`else
               keep_next   = 1'b0;
`endif
            end else begin
               res_hi_next = rem;
               res_lo_next = quot;
            end
         end
         default: begin
            res_hi_next = 32'd0;
            res_lo_next = 32'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg    <= 4'd0;
         hi_reg     <= 32'd0;
         lo_reg     <= 32'd0;
         res_hi_reg <= 32'd0;
         res_lo_reg <= 32'd0;
         keep_reg   <= 1'b0;
      end else if (busy) begin
         // Starts while busy are dropped; hazard logic holds them in D.
         cnt_reg <= cnt_reg - 4'd1;
         if (cnt_reg == 4'd1 && !keep_reg) begin
            hi_reg <= res_hi_reg;
            lo_reg <= res_lo_reg;
         end
      end else if (start) begin
         case (md_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
               cnt_reg    <= md_op[1] ? DIV_LOAD : MULT_LOAD;
               res_hi_reg <= res_hi_next;
               res_lo_reg <= res_lo_next;
               keep_reg   <= keep_next;
            end
            OP_MTHI: hi_reg <= a;
            OP_MTLO: lo_reg <= a;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer with default cycle counts (5 mult, 10 div).
module tb_mdu_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] a;
   logic [31:0] b;
   logic        d_is_md;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        md_stall;

   int checks = 0;
   int errors = 0;
   int n;

   mdu_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
      .d_is_md(d_is_md), .busy(busy), .hi(hi), .lo(lo), .md_stall(md_stall)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op, then count cycles busy stays high (bounded).
   task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         output int cyc);
      start = 1'b1; md_op = op; a = av; b = bv;
      tick();
      start = 1'b0;
      cyc = 0;
      while (busy && cyc < 40) begin
         cyc++;
         tick();
      end
      $display("op=%0d a=%h b=%h busy_cycles=%0d hi=%h lo=%h", op, av, bv, cyc, hi, lo);
   endtask

   initial begin
      reset = 1'b1; start = 1'b1; md_op = 3'd0; a = 32'd3; b = 32'd3; d_is_md = 1'b1;
      #1;
      chk("reset_stall", {31'd0, md_stall}, 32'd1);
      tick();
      tick();
      start = 1'b0; reset = 1'b0; d_is_md = 1'b0;
      #1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      tick();
      chk("reset_start_dropped", {31'd0, busy}, 32'd0);

      run_op(3'd0, 32'hFFFF_FFFF, 32'd2, n);
      chk("mult_cycles", n, 32'd5);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFFE);
      run_op(3'd1, 32'hFFFF_FFFF, 32'd2, n);
      chk("multu_b2b_cycles", n, 32'd5);
      chk("multu_hi", hi, 32'h0000_0001);
      chk("multu_lo", lo, 32'hFFFF_FFFE);

      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, n);
      chk("div_cycles", n, 32'd10);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);
      run_op(3'd2, 32'd7, 32'hFFFF_FFFE, n);
      chk("div_negden_lo", lo, 32'hFFFF_FFFD);
      chk("div_negden_hi", hi, 32'd1);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
      chk("div_ovf_lo", lo, 32'h8000_0000);
      chk("div_ovf_hi", hi, 32'd0);
      run_op(3'd3, 32'd7, 32'd2, n);
      chk("divu_lo", lo, 32'd3);
      chk("divu_hi", hi, 32'd1);

      run_op(3'd4, 32'd5, 32'd0, n);
      chk("mthi_cycles", n, 32'd0);
      chk("mthi_hi", hi, 32'd5);
      run_op(3'd5, 32'd6, 32'd0, n);
      chk("mtlo_lo", lo, 32'd6);
      run_op(3'd6, 32'hDEAD_BEEF, 32'd1, n);
      chk("rsvd_cycles", n, 32'd0);
      chk("rsvd_hi", hi, 32'd5);
      chk("rsvd_lo", lo, 32'd6);
      run_op(3'd3, 32'd7, 32'd0, n);
      chk("divz_cycles", n, 32'd10);
`ifdef MDU_DIVZERO_KEEP_EN
      chk("divz_hi", hi, 32'd5);
      chk("divz_lo", lo, 32'd6);
`else
      chk("divz_hi", hi, 32'd7);
      chk("divz_lo", lo, 32'hFFFF_FFFF);
`endif

      // Ignored mthi while a mult is in flight.
      reset = 1'b1; tick(); reset = 1'b0;
      d_is_md = 1'b1; start = 1'b0; md_op = 3'd7;
      #1;
      chk("stall_idle", {31'd0, md_stall}, 32'd0);
      md_op = 3'd0; a = 32'd3; b = 32'd4; start = 1'b1;
      #1;
      chk("stall_start_cycle", {31'd0, md_stall}, 32'd1);
      tick();
      start = 1'b0;
      tick();
      start = 1'b1; md_op = 3'd4; a = 32'd9;
      #1;
      n = 1;
      while (busy && n < 40) begin
         chk("stall_busy", {31'd0, md_stall}, 32'd1);
         n++;
         tick();
      end
      start = 1'b0;
      $display("mult 3x4 with held mthi: busy_cycles=%0d hi=%h lo=%h", n, hi, lo);
      chk("ign_cycles", n, 32'd5);
      chk("ign_hi", hi, 32'd0);
      chk("ign_lo", lo, 32'd12);
      d_is_md = 1'b0;

      start = 1'b1; md_op = 3'd5; a = 32'h1234_5678;
      tick();
      start = 1'b0;
      chk("mtlo2_lo", lo, 32'h1234_5678);
      chk("mtlo2_busy", {31'd0, busy}, 32'd0);
      chk("mtlo2_hi", hi, 32'd0);

      // Reset in the middle of a divide discards the pending result.
      start = 1'b1; md_op = 3'd2; a = 32'd100; b = 32'd7;
      tick();
      start = 1'b0;
      chk("rstmid_busy1", {31'd0, busy}, 32'd1);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rstmid_busy", {31'd0, busy}, 32'd0);
      chk("rstmid_hi", hi, 32'd0);
      chk("rstmid_lo", lo, 32'd0);
      repeat (15) tick();
      $display("after mid-op reset: busy=%0d hi=%h lo=%h", busy, hi, lo);
      chk("rstmid_late_hi", hi, 32'd0);
      chk("rstmid_late_lo", lo, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
